// File: rtl/bitstream_window_buffer.sv
// Bit-level window buffer feeding the Exp-Golomb decoder: packs 16-bit words
// into a 32-bit MSB-aligned buffer and exposes the oldest 16 bits as a window.
module bitstream_window_buffer (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        consume_valid,
   input  logic [4:0]  consume_len,
   input  logic        sync_clear,
   output logic [15:0] window,
   output logic        window_valid,
   output logic [5:0]  fill_level,
   output logic [15:0] bit_pos,
   output logic        proto_err
);

   // Handshake: a word transfers on a rising edge where in_valid && in_ready.
   // in_ready is decoded from registered fill and sync_clear only, so the
   // decoder's consume request never combinationally gates the source.

   logic [31:0] buf_reg;
   logic [5:0]  fill;
   logic [15:0] pos_reg;
   logic        err_reg;

   logic        len_legal;
   logic        consume_ok;
   logic        consume_bad;
   logic [4:0]  acc_len;
   logic        load;
   logic [31:0] shifted;
   logic [31:0] loaded;
   logic [31:0] buf_next;
   logic [5:0]  fill_after;
   logic [5:0]  fill_next;
   logic [15:0] pos_next;
   logic        err_next;

   assign window       = buf_reg[31:16];
   assign window_valid = (fill >= 6'd16);
   assign fill_level   = fill;
   assign bit_pos      = pos_reg;
   assign proto_err    = err_reg;
   assign in_ready     = (fill <= 6'd16) && !sync_clear;

   // Consume is applied first; the incoming word lands directly behind the
   // bits that survive the shift, so both can happen on one edge.
   always_comb begin
      len_legal   = (consume_len <= 5'd16);
      consume_ok  = consume_valid && window_valid && len_legal;
      consume_bad = consume_valid && !(window_valid && len_legal);
      acc_len     = consume_ok ? consume_len : 5'd0;
      load        = in_valid && in_ready;
      shifted     = buf_reg << acc_len;
      fill_after  = fill - {1'b0, acc_len};
      loaded      = {in_data, 16'h0000} >> fill_after;
      buf_next    = load ? (shifted | loaded) : shifted;
      fill_next   = load ? (fill_after + 6'd16) : fill_after;
      pos_next    = pos_reg + {11'd0, acc_len};
      err_next    = err_reg | consume_bad;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_reg <= 32'h0;
         fill    <= 6'd0;
         pos_reg <= 16'h0;
         err_reg <= 1'b0;
      end else if (sync_clear) begin
         buf_reg <= 32'h0;
         fill    <= 6'd0;
         pos_reg <= 16'h0;
         err_reg <= 1'b0;
      end else begin
         buf_reg <= buf_next;
         fill    <= fill_next;
         pos_reg <= pos_next;
         err_reg <= err_next;
      end
   end

endmodule

// File: tb/tb_bitstream_window_buffer.sv
// Self-checking bench for bitstream_window_buffer using a bit-queue reference
// model and an expected-snapshot queue.
module tb_bitstream_window_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        consume_valid;
   logic [4:0]  consume_len;
   logic        sync_clear;
   logic [15:0] window;
   logic        window_valid;
   logic [5:0]  fill_level;
   logic [15:0] bit_pos;
   logic        proto_err;

   bitstream_window_buffer dut (
      .clk           (clk),
      .reset         (reset),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .consume_valid (consume_valid),
      .consume_len   (consume_len),
      .sync_clear    (sync_clear),
      .window        (window),
      .window_valid  (window_valid),
      .fill_level    (fill_level),
      .bit_pos       (bit_pos),
      .proto_err     (proto_err)
   );

   always #5 clk = ~clk;

   // Reference model: queue of buffered bits, index 0 is the oldest.
   bit          mq[$];
   logic [15:0] m_pos;
   logic        m_err;
   logic [39:0] exp_q[$];
   int          total = 0;
   int          bad = 0;

   function automatic logic [39:0] model_snap();
      logic [15:0] w;
      logic [5:0]  f;
      w = 16'h0;
      for (int i = 0; i < 16; i++)
         if (i < mq.size()) w[15-i] = mq[i];
      f = 6'(mq.size());
      return {w, f, (mq.size() >= 16), m_pos, m_err};
   endfunction

   task automatic model_clear();
      mq.delete();
      m_pos = 16'h0;
      m_err = 1'b0;
   endtask

   // One clock of stimulus: drive, check in_ready mid-cycle, predict, compare after the edge.
   task automatic step(input logic iv, input logic [15:0] d, input logic cv,
                       input logic [4:0] cl, input logic sc);
      logic        rdy;
      logic [39:0] e;
      logic [39:0] g;
      @(negedge clk);
      in_valid      = iv;
      in_data       = d;
      consume_valid = cv;
      consume_len   = cl;
      sync_clear    = sc;
      rdy = (mq.size() <= 16) && !sc;
      #1;
      total++;
      if (in_ready !== rdy) begin
         bad++;
         $display("FAIL in_ready got=%b exp=%b t=%0t", in_ready, rdy, $time);
      end
      if (sc) begin
         model_clear();
      end else begin
         if (cv) begin
            if (mq.size() >= 16 && cl <= 16) begin
               for (int i = 0; i < int'(cl); i++) void'(mq.pop_front());
               m_pos = m_pos + 16'(cl);
            end else begin
               m_err = 1'b1;
            end
         end
         if (iv && rdy)
            for (int i = 15; i >= 0; i--) mq.push_back(d[i]);
      end
      exp_q.push_back(model_snap());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      g = {window, fill_level, window_valid, bit_pos, proto_err};
      total++;
      if (g !== e) begin
         bad++;
         $display("FAIL snapshot got win=%h fill=%0d vld=%b pos=%0d err=%b exp win=%h fill=%0d vld=%b pos=%0d err=%b",
                  g[39:24], g[23:18], g[17], g[16:1], g[0], e[39:24], e[23:18], e[17], e[16:1], e[0]);
      end
      in_valid      = 1'b0;
      consume_valid = 1'b0;
      sync_clear    = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b0; in_data = 16'h0; consume_valid = 1'b0; consume_len = 5'd0; sync_clear = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      total++;
      if ({window, fill_level, window_valid, in_ready, bit_pos, proto_err} !== {16'h0, 6'd0, 1'b0, 1'b1, 16'h0, 1'b0}) begin
         bad++;
         $display("FAIL reset_values got win=%h fill=%0d vld=%b rdy=%b pos=%0d err=%b",
                  window, fill_level, window_valid, in_ready, bit_pos, proto_err);
      end
      reset = 1'b0;
   endtask

   task automatic test_load();
      step(1'b1, 16'hA5C3, 1'b0, 5'd0, 1'b0);
      step(1'b1, 16'h0F0F, 1'b0, 5'd0, 1'b0);
      total++;
      if ({window, fill_level, in_ready, window_valid} !== {16'hA5C3, 6'd32, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL load_two got win=%h fill=%0d rdy=%b vld=%b exp win=a5c3 fill=32 rdy=0 vld=1",
                  window, fill_level, in_ready, window_valid);
      end
   endtask

   task automatic test_consume();
      step(1'b0, 16'h0, 1'b1, 5'd3, 1'b0);
      total++;
      if ({window, fill_level, bit_pos} !== {16'h2E18, 6'd29, 16'd3}) begin
         bad++;
         $display("FAIL consume3 got win=%h fill=%0d pos=%0d exp win=2e18 fill=29 pos=3", window, fill_level, bit_pos);
      end
      step(1'b0, 16'h0, 1'b1, 5'd13, 1'b0);
      total++;
      if ({window, fill_level, in_ready, bit_pos} !== {16'h0F0F, 6'd16, 1'b1, 16'd16}) begin
         bad++;
         $display("FAIL consume13 got win=%h fill=%0d rdy=%b pos=%0d exp win=0f0f fill=16 rdy=1 pos=16",
                  window, fill_level, in_ready, bit_pos);
      end
   endtask

   task automatic test_back_to_back();
      step(1'b1, 16'h1234, 1'b1, 5'd4, 1'b0);
      total++;
      if ({window, fill_level, bit_pos} !== {16'hF0F1, 6'd28, 16'd20}) begin
         bad++;
         $display("FAIL consume_and_load got win=%h fill=%0d pos=%0d exp win=f0f1 fill=28 pos=20", window, fill_level, bit_pos);
      end
   endtask

   task automatic test_errors();
      step(1'b0, 16'h0, 1'b1, 5'd17, 1'b0);
      total++;
      if ({window, fill_level, bit_pos, proto_err} !== {16'hF0F1, 6'd28, 16'd20, 1'b1}) begin
         bad++;
         $display("FAIL len17 got win=%h fill=%0d pos=%0d err=%b exp win=f0f1 fill=28 pos=20 err=1",
                  window, fill_level, bit_pos, proto_err);
      end
      step(1'b0, 16'h0, 1'b1, 5'd12, 1'b0);
      step(1'b0, 16'h0, 1'b1, 5'd8, 1'b0);
      step(1'b0, 16'h0, 1'b1, 5'd4, 1'b0);
      total++;
      if ({fill_level, bit_pos, proto_err} !== {6'd8, 16'd40, 1'b1}) begin
         bad++;
         $display("FAIL underflow got fill=%0d pos=%0d err=%b exp fill=8 pos=40 err=1", fill_level, bit_pos, proto_err);
      end
      step(1'b1, 16'hBEEF, 1'b1, 5'd2, 1'b1);
      total++;
      if ({fill_level, bit_pos, proto_err, window} !== {6'd0, 16'd0, 1'b0, 16'h0}) begin
         bad++;
         $display("FAIL sync_clear got fill=%0d pos=%0d err=%b win=%h exp fill=0 pos=0 err=0 win=0000",
                  fill_level, bit_pos, proto_err, window);
      end
   endtask

   task automatic test_wrap();
      step(1'b1, 16'(($urandom)), 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 4097; i++)
         step(1'b1, 16'($urandom), 1'b1, 5'd16, 1'b0);
      total++;
      if ({bit_pos, proto_err, fill_level} !== {16'd16, 1'b0, 6'd16}) begin
         bad++;
         $display("FAIL bit_pos_wrap got pos=%0d err=%b fill=%0d exp pos=16 err=0 fill=16", bit_pos, proto_err, fill_level);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
              5'($urandom_range(0, 18)), $urandom_range(0, 60) == 0);
   endtask

   task automatic test_async_reset();
      step(1'b0, 16'h0, 1'b0, 5'd0, 1'b1);
      step(1'b1, 16'h8001, 1'b0, 5'd0, 1'b0);
      step(1'b1, 16'h7FFE, 1'b0, 5'd0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 5'd8, 1'b0);
      total++;
      if (fill_level !== 6'd24) begin
         bad++;
         $display("FAIL prefill24 got fill=%0d exp fill=24", fill_level);
      end
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      model_clear();
      total++;
      if ({window, fill_level, window_valid, in_ready, bit_pos, proto_err} !== {16'h0, 6'd0, 1'b0, 1'b1, 16'h0, 1'b0}) begin
         bad++;
         $display("FAIL async_reset got win=%h fill=%0d vld=%b rdy=%b pos=%0d err=%b",
                  window, fill_level, window_valid, in_ready, bit_pos, proto_err);
      end
      @(negedge clk);
      reset = 1'b0;
      step(1'b1, 16'hC001, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_load();
      test_consume();
      test_back_to_back();
      test_errors();
      test_wrap();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
